// File: rtl/grant_mux_pkg.sv
// Shared definitions for the grant-driven burst mux: FSM encoding, channel count,
// and the one-hot to binary index helper.
package grant_mux_pkg;

   localparam int NUM_CH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   // Returns the index of the highest set bit; only meaningful for a one-hot input.
   function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/grant_mux_grant_decode.sv
// Combinational grant classifier: binary index, exactly-one-set flag, multi-hot flag.
// Zero latency, no flow control.
module grant_decode
   import grant_mux_pkg::*;
(
   input  logic [NUM_CH-1:0] grant_i,
   output logic [1:0]        idx_o,
   output logic              one_hot_o,
   output logic              multi_hot_o
);

   always_comb begin
      idx_o       = onehot_to_idx(grant_i);
      one_hot_o   = ($countones(grant_i) == 1);
      multi_hot_o = ($countones(grant_i) > 1);
   end

endmodule

// File: rtl/grant_mux.sv
// Latches a one-hot grant and forwards BURST_LEN beats from that channel through a
// one-deep output register (1-cycle latency); a held, unaccepted beat stalls the channel.
module grant_mux
   import grant_mux_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        grant,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_src,
   output logic                     out_last,
   output logic                     burst_done,
   output logic                     grant_err
);

   localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

   state_e              state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [1:0]          out_src_q, out_src_d;
   logic                out_last_q, out_last_d;
   logic                burst_done_q, burst_done_d;
   logic                grant_err_q, grant_err_d;

   logic [1:0]          dec_idx;
   logic                dec_one_hot;
   logic                dec_multi_hot;
   logic                load_ok;
   logic                accept;
   logic                last_beat;

   grant_decode u_grant_decode (
      .grant_i     (grant),
      .idx_o       (dec_idx),
      .one_hot_o   (dec_one_hot),
      .multi_hot_o (dec_multi_hot)
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      out_last_d   = out_last_q;
      burst_done_d = 1'b0;
      grant_err_d  = 1'b0;

      // The output register can take a beat when empty or draining this cycle.
      load_ok   = (state_q == XFER) && (!out_valid_q || out_ready);
      accept    = load_ok && ch_valid[sel_q];
      last_beat = (cnt_q == LAST_CNT);

      unique case (state_q)
         IDLE: begin
            if (dec_one_hot) begin
               sel_d   = dec_idx;
               cnt_d   = 4'd0;
               state_d = XFER;
            end else begin
               grant_err_d = dec_multi_hot;
            end
         end
         XFER: begin
            if (accept) begin
               if (last_beat) state_d = IDLE;
               else           cnt_d   = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         out_valid_d  = 1'b1;
         out_data_d   = ch_data[int'(sel_q)*DATA_W +: DATA_W];
         out_src_d    = sel_q;
         out_last_d   = last_beat;
         burst_done_d = last_beat;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= 2'd0;
         cnt_q        <= 4'd0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= 2'd0;
         out_last_q   <= 1'b0;
         burst_done_q <= 1'b0;
         grant_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         out_last_q   <= out_last_d;
         burst_done_q <= burst_done_d;
         grant_err_q  <= grant_err_d;
      end
   end

   assign ch_ready   = load_ok ? (4'b0001 << sel_q) : 4'b0000;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_src    = out_src_q;
   assign out_last   = out_last_q;
   assign burst_done = burst_done_q;
   assign grant_err  = grant_err_q;

endmodule

// File: tb/tb_grant_mux.sv
// Drives a BURST_LEN=4 and a BURST_LEN=1 instance with identical stimulus and compares
// every output each cycle against a burst-level reference model.
module tb_grant_mux;

   logic        clk;
   logic        rst_n;
   logic [3:0]  grant;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid;
   logic        out_ready;

   logic [3:0]  rdy   [2];
   logic [7:0]  od    [2];
   logic        ov    [2];
   logic [1:0]  osrc  [2];
   logic        olast [2];
   logic        bdone [2];
   logic        gerr  [2];

   int n_chk = 0;
   int n_err = 0;

   // Reference model: a channel owns the mux until it has delivered its burst length.
   bit         m_busy  [2];
   int         m_sel   [2];
   int         m_beats [2];
   bit         m_ov    [2];
   logic [7:0] m_od    [2];
   int         m_src   [2];
   bit         m_last  [2];
   bit         m_done  [2];
   bit         m_err   [2];

   grant_mux #(.DATA_W(8), .BURST_LEN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .grant(grant), .ch_data(ch_data), .ch_valid(ch_valid),
      .ch_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .out_src(osrc[0]), .out_last(olast[0]), .burst_done(bdone[0]), .grant_err(gerr[0])
   );

   grant_mux #(.DATA_W(8), .BURST_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .grant(grant), .ch_data(ch_data), .ch_valid(ch_valid),
      .ch_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .out_src(osrc[1]), .out_last(olast[1]), .burst_done(bdone[1]), .grant_err(gerr[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0; m_sel[d] = 0; m_beats[d] = 0; m_ov[d] = 0; m_od[d] = 8'h00;
         m_src[d] = 0; m_last[d] = 0; m_done[d] = 0; m_err[d] = 0;
      end
   endtask

   task automatic check_outputs(input int d);
      logic [3:0] er;
      er = (m_busy[d] && (!m_ov[d] || out_ready)) ? (4'b0001 << m_sel[d]) : 4'b0000;
      chk($sformatf("d%0d ch_ready", d),   32'(rdy[d]),   32'(er));
      chk($sformatf("d%0d out_valid", d),  32'(ov[d]),    32'(m_ov[d]));
      chk($sformatf("d%0d out_data", d),   32'(od[d]),    32'(m_od[d]));
      chk($sformatf("d%0d out_src", d),    32'(osrc[d]),  32'(m_src[d]));
      chk($sformatf("d%0d out_last", d),   32'(olast[d]), 32'(m_last[d]));
      chk($sformatf("d%0d burst_done", d), 32'(bdone[d]), 32'(m_done[d]));
      chk($sformatf("d%0d grant_err", d),  32'(gerr[d]),  32'(m_err[d]));
   endtask

   // Inputs are set at the falling edge; check, advance the model, then run one clock.
   task automatic step();
      #1;
      for (int d = 0; d < 2; d++) check_outputs(d);
      for (int d = 0; d < 2; d++) begin : upd
         int bl, n1;
         bit ok, take, fin, idle;
         bl   = (d == 0) ? 4 : 1;
         n1   = $countones(grant);
         ok   = m_busy[d] && (!m_ov[d] || out_ready);
         take = ok && ch_valid[m_sel[d]];
         fin  = take && (m_beats[d] == bl - 1);
         idle = !m_busy[d];
         m_err[d]  = idle && (n1 > 1);
         m_done[d] = fin;
         if (take) begin
            m_ov[d]   = 1;
            m_od[d]   = ch_data[m_sel[d]*8 +: 8];
            m_src[d]  = m_sel[d];
            m_last[d] = fin;
            if (fin) m_busy[d] = 0;
            else     m_beats[d]++;
         end else if (out_ready) begin
            m_ov[d] = 0;
         end
         if (idle && n1 == 1) begin
            m_busy[d]  = 1;
            m_beats[d] = 0;
            for (int c = 0; c < 4; c++) if (grant[c]) m_sel[d] = c;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 2; d++) check_outputs(d);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] beats_q[$];
      logic       lasts_q[$];
      int         dones, src0;
      clk = 1'b0; rst_n = 1'b1; grant = 4'h0; ch_data = 32'h0; ch_valid = 4'h0; out_ready = 1'b1;
      @(negedge clk);
      do_reset();
      step();

      // Channel 2 burst with incrementing data A0..A3
      grant = 4'b0100; ch_valid = 4'b0100; out_ready = 1'b1; ch_data = {4{8'hA0}};
      step();
      grant = 4'b0000; dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (ov[0]) begin beats_q.push_back(od[0]); lasts_q.push_back(olast[0]); end
         if (bdone[0]) dones++;
         ch_data = {4{8'hA0 + 8'(m_beats[0])}};
         step();
      end
      chk("burst beats", 32'(beats_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("burst data", 32'(beats_q[i]), 32'(8'hA0 + i));
         chk("burst last", 32'(lasts_q[i]), 32'(i == 3));
      end
      chk("burst done count", 32'(dones), 32'd1);

      // Multi-hot grant in IDLE
      ch_valid = 4'b1111; grant = 4'b0011;
      step();
      grant = 4'b0000;
      for (int i = 0; i < 3; i++) step();

      // Channel 1 burst with a three-cycle downstream stall after the second beat
      grant = 4'b0010; ch_valid = 4'b0010;
      step();
      grant = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         out_ready = !(i >= 3 && i <= 5);
         ch_data = $urandom;
         step();
      end
      out_ready = 1'b1;

      // Grant moves to channel 3 mid-burst on channel 0
      grant = 4'b0001; ch_valid = 4'b1001; src0 = 0;
      step();
      grant = 4'b1000;
      for (int i = 0; i < 12; i++) begin
         if (ov[0] && osrc[0] == 2'd0) src0++;
         ch_data = $urandom;
         step();
      end
      chk("chan0 beats before chan3", 32'(src0), 32'd4);
      grant = 4'b0000;
      for (int i = 0; i < 4; i++) step();

      // Reset in the middle of a burst, then a full channel-1 burst
      grant = 4'b0010; ch_valid = 4'b1111;
      step();
      grant = 4'b0000;
      for (int i = 0; i < 2; i++) begin ch_data = $urandom; step(); end
      do_reset();
      grant = 4'b0010;
      step();
      grant = 4'b0000;
      for (int i = 0; i < 7; i++) begin ch_data = $urandom; step(); end

      // One grant per channel in turn
      for (int g = 0; g < 4; g++) begin
         grant = 4'b0001 << g;
         step();
         grant = 4'b0000;
         for (int i = 0; i < 6; i++) begin ch_data = $urandom; step(); end
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3)      grant = 4'b0000;
         else if (r < 9) grant = 4'b0001 << $urandom_range(0, 3);
         else            grant = 4'($urandom);
         ch_valid  = 4'($urandom);
         ch_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else                             step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/grant_mux.md
GRANT_MUX -- requirements
Module: grant_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning per-channel data width.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning beats per grant; legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port grant  input  4  one-hot grant from the upstream 4-way round-robin arbiter; 0 = idle.
REQ-006 SHALL have port ch_data  input  4*DATA_W  channel n occupies bits [n*DATA_W +: DATA_W].
REQ-007 SHALL have port ch_valid  input  4  per-channel beat valid.
REQ-008 SHALL have port ch_ready  output  4  per-channel beat accept.
REQ-009 SHALL have port out_data  output  DATA_W  registered muxed beat.
REQ-010 SHALL have port out_valid  output  1  out_data holds a beat.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_src  output  2  binary index of the channel that sourced out_data.
REQ-013 SHALL have port out_last  output  1  out_data is the final beat of its burst.
REQ-014 SHALL have port burst_done  output  1  one-cycle pulse when the last beat of a burst is loaded into the output register.
REQ-015 SHALL have port grant_err  output  1  one-cycle pulse on a multi-hot grant sampled in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE and XFER.
REQ-017 In IDLE with exactly one grant bit set, SHALL latch its index into sel, clear beat counter, enter XFER next cycle.
REQ-018 In IDLE with grant == 0, SHALL remain in IDLE.
REQ-019 In IDLE with two or more grant bits set, SHALL pulse grant_err next cycle and remain in IDLE.
REQ-020 In XFER, grant changes SHALL be ignored until the burst completes.
REQ-021 ch_ready[sel] SHALL equal (state==XFER) && (!out_valid || out_ready); all other ch_ready bits SHALL be 0; ch_ready is combinational.
REQ-022 A beat SHALL be accepted when ch_valid[sel] && ch_ready[sel]; it appears on out_data/out_src with out_valid=1 the next cycle (latency 1).
REQ-023 Beat counter width SHALL be 4 bits; it increments per accepted beat and never wraps within a burst.
REQ-024 The accepted beat with counter == BURST_LEN-1 SHALL set out_last=1 with that beat, pulse burst_done, and return the FSM to IDLE.
REQ-025 Output register SHALL hold out_data/out_src/out_last stable while out_valid && !out_ready.
REQ-026 out_valid SHALL clear after out_ready handshake unless a new beat loads in the same cycle (back-to-back full throughput).
REQ-027 A new grant MAY be latched in IDLE while the previous last beat is still held; no new beat loads until REQ-021 permits.
REQ-028 With BURST_LEN == 1, every accepted beat SHALL carry out_last=1 and each grant SHALL produce exactly one beat.
REQ-029 ch_valid deasserting mid-burst SHALL stall the burst without losing counter state.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, sel=0, counter=0, out_valid=0, out_data=0, out_src=0, out_last=0, burst_done=0, grant_err=0.
REQ-031 Reset asserted mid-burst SHALL discard the burst and any held output beat; no partial out_last is emitted after release.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding (IDLE=1'b0, XFER=1'b1), channel count constant 4, and the one-hot-to-index function.
REQ-033 One sub-module is natural: grant_decode (combinational one-hot check returning index, valid, multi_hot); all sequential logic stays in grant_mux.

Verification
REQ-034 grant=4'b0100, ch_valid[2]=1 continuously, out_ready=1, data 0xA0..0xA3 -> four consecutive out_valid beats, out_src=2, out_last only on 0xA3, one burst_done pulse.
REQ-035 grant=4'b0011 in IDLE -> grant_err pulses once, ch_ready stays 4'b0000, FSM stays IDLE.
REQ-036 XFER on channel 1, out_ready held 0 for 3 cycles after beat 2 -> out_data frozen at beat 2, ch_ready[1]=0, counter resumes with no loss or duplicate.
REQ-037 grant switches 4'b0001 -> 4'b1000 at beat 1 of a channel-0 burst -> remaining beats still out_src=0; channel-3 burst starts only after burst_done.
REQ-038 rst_n pulsed low at beat 2 of 4 -> all outputs 0 immediately; after release, a new grant=4'b0010 yields a full 4-beat burst from channel 1.
REQ-039 BURST_LEN=1, grants 0001,0010,0100,1000 in sequence -> four beats, out_src 0,1,2,3, each with out_last=1 and burst_done.
